// File: rtl/pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// pc_redirect_unit
//
// Fetch-PC stage that sits directly downstream of the branch-offset shifter.
// It holds the architectural fetch PC and sequences these events:
//   - normal +4 increment
//   - hold while the hazard unit stalls
//   - branch/JAL or JALR redirect, followed by a flush window
//   - trap on a misaligned redirect target
//
// Configuration macro: RVC_TARGETS_EN
//   undefined (default) : a target with bit 1 set traps to TRAP_PC.
//   defined             : halfword-aligned targets are legal, the trap path
//                         is unreachable and misalign_o is tied low.
//   The sequential increment stays +4 in both builds.
//
// Parameters:
//   N            PC / datapath width
//   RESET_PC     PC loaded on reset
//   TRAP_PC      PC loaded on a misaligned-target trap
//   FLUSH_CYCLES cycles flush_o stays high after a redirect (1..7)
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset, overrides all inputs
//   stall_i        in   hold the PC
//   br_taken_i     in   EX branch/JAL resolved taken
//   br_pc_i        in   PC of the branch in EX
//   br_offset_i    in   sign-extended immediate, already shifted left by 1
//   jalr_i         in   EX JALR valid (wins over br_taken_i)
//   jalr_target_i  in   rs1+imm from the ALU
//   trap_ack_i     in   trap handler acknowledge
//   pc_o           out  current fetch PC (registered)
//   pc_plus4_o     out  pc_o + 4 (combinational)
//   flush_o        out  kill IF/ID and ID/EX contents (registered)
//   misalign_o     out  misaligned-target trap pending (registered)
// ---------------------------------------------------------------------------
module pc_redirect_unit #(
  parameter int            N            = 32,
  parameter logic [N-1:0]  RESET_PC     = '0,
  parameter logic [N-1:0]  TRAP_PC      = N'('h100),
  parameter int            FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_i,
  input  logic         br_taken_i,
  input  logic [N-1:0] br_pc_i,
  input  logic [N-1:0] br_offset_i,
  input  logic         jalr_i,
  input  logic [N-1:0] jalr_target_i,
  input  logic         trap_ack_i,
  output logic [N-1:0] pc_o,
  output logic [N-1:0] pc_plus4_o,
  output logic         flush_o,
  output logic         misalign_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    TRAP  = 2'd2
  } state_t;

  localparam logic [N-1:0] PC_INC     = N'(4);
  localparam logic [2:0]   FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_t       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         flush_q, flush_d;
  logic         misalign_q, misalign_d;

  logic [N-1:0] br_tgt;
  logic [N-1:0] jalr_tgt;
  logic [N-1:0] target;
  logic [N-1:0] seq_pc;
  logic         redirect;
  logic         misaligned;

  // Redirect target selection. The branch sum wraps silently modulo 2^N.
  // JALR clears bit 0 of its target, so only bit 1 can make a target
  // misaligned. JALR wins when both sources fire in the same cycle.
  always_comb begin
    br_tgt   = br_pc_i + br_offset_i;
    jalr_tgt = {jalr_target_i[N-1:1], 1'b0};
    redirect = jalr_i | br_taken_i;
    target   = jalr_i ? jalr_tgt : br_tgt;
`ifdef RVC_TARGETS_EN
    misaligned = 1'b0;
`else
    misaligned = target[1];
`endif
  end

  // Sequential PC used whenever no redirect is accepted: +4, or hold on stall.
  always_comb begin
    seq_pc = stall_i ? pc_q : (pc_q + PC_INC);
  end

  // Next-state and next-output logic.
  // In FLUSH the counter runs regardless of stall so that the flush window
  // length is fixed; redirects arriving in FLUSH come from instructions that
  // are themselves being killed, so they are dropped. In TRAP the PC is
  // pinned to TRAP_PC until the handler acknowledges.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    flush_d    = flush_q;
    misalign_d = misalign_q;

    unique case (state_q)
      RUN: begin
        flush_d = 1'b0;
        if (redirect) begin
          flush_d = 1'b1;
          if (misaligned) begin
            pc_d       = TRAP_PC;
            misalign_d = 1'b1;
            state_d    = TRAP;
          end else begin
            pc_d    = target;
            cnt_d   = FLUSH_INIT;
            state_d = FLUSH;
          end
        end else begin
          pc_d = seq_pc;
        end
      end

      FLUSH: begin
        pc_d = seq_pc;
        if (cnt_q <= 3'd1) begin
          cnt_d   = 3'd0;
          flush_d = 1'b0;
          state_d = RUN;
        end else begin
          cnt_d   = cnt_q - 3'd1;
          flush_d = 1'b1;
        end
      end

      TRAP: begin
        pc_d       = TRAP_PC;
        flush_d    = 1'b0;
        misalign_d = 1'b1;
        if (trap_ack_i) begin
          misalign_d = 1'b0;
          state_d    = RUN;
        end
      end

      default: begin
        state_d    = RUN;
        flush_d    = 1'b0;
        misalign_d = 1'b0;
        cnt_d      = 3'd0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      cnt_q      <= 3'd0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + PC_INC;
  assign flush_o    = flush_q;

`ifdef RVC_TARGETS_EN
  assign misalign_o = 1'b0;
`else
  assign misalign_o = misalign_q;
`endif

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Program-counter stage that sits directly downstream of the branch-offset left-shifter.
- Holds the architectural fetch PC and sequences normal increment, stall hold, branch/JALR redirect, post-redirect flush and misaligned-target trap.
- Consumes the already-shifted branch offset and the branch PC from EX; drives instruction-memory address and flush control to the IF/ID and ID/EX registers.

Parameters:
- N, 32, datapath/PC width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_PC, 32'h0000_0100, PC loaded on a misaligned-target trap.
- FLUSH_CYCLES, 2, number of cycles flush_o stays high after a redirect (range 1..7).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_i  input  1  hazard-unit stall; hold PC.
- br_taken_i  input  1  EX-stage branch/JAL resolved taken.
- br_pc_i  input  N  PC of the branch instruction in EX.
- br_offset_i  input  N  sign-extended immediate already shifted left by 1.
- jalr_i  input  1  EX-stage JALR valid.
- jalr_target_i  input  N  rs1+imm from ALU.
- trap_ack_i  input  1  trap handler acknowledge.
- pc_o  output  N  current fetch PC.
- pc_plus4_o  output  N  pc_o + 4, combinational.
- flush_o  output  1  kill IF/ID and ID/EX contents.
- misalign_o  output  1  misaligned-target trap pending.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). rst overrides every other input.
- Reset values: pc_o=RESET_PC, flush_o=0, misalign_o=0, state=RUN, flush counter=0.
- Target arithmetic:
  - br_tgt = br_pc_i + br_offset_i, modulo 2^N; wrap-around is silent.
  - jalr_tgt = jalr_target_i with bit 0 forced to 0.
- Target select: if jalr_i and br_taken_i are both high, jalr_i wins. redirect = jalr_i | br_taken_i.
- Misaligned: selected target bit 1 = 1 (bit 0 cannot be set after the forcing above).
- States:
  - RUN:
    - redirect and aligned: pc_o <= target, counter <= FLUSH_CYCLES, flush_o <= 1, go to FLUSH.
    - redirect and misaligned: pc_o <= TRAP_PC, misalign_o <= 1, flush_o <= 1, go to TRAP.
    - else if stall_i: pc_o held.
    - else: pc_o <= pc_o + 4.
    - Redirect overrides stall_i; a redirect is never lost.
  - FLUSH:
    - counter decrements each cycle; flush_o stays high while counter != 0. flush_o is high for exactly FLUSH_CYCLES cycles.
    - PC keeps advancing by +4 (or holds under stall_i). Stall does not freeze the counter.
    - At counter = 1, flush_o drops the next cycle and the state returns to RUN.
    - A new redirect in FLUSH is ignored (those EX instructions are being flushed).
  - TRAP:
    - pc_o held at TRAP_PC; misalign_o=1; flush_o=1 on the entry cycle only, then 0.
    - redirect and stall_i are ignored.
    - trap_ack_i=1: misalign_o <= 0, go to RUN. From the next cycle PC increments from TRAP_PC.
- rst asserted mid-FLUSH or mid-TRAP returns to the reset values on the next edge.
- Latency: redirect to new pc_o is 1 cycle. pc_plus4_o has 0-cycle latency.

Optional Feature:
- Macro RVC_TARGETS_EN.
- Defined: halfword-aligned targets are legal; the misalign check is disabled and TRAP is unreachable; misalign_o is tied to 0.
- Not defined: the behaviour above, where bit 1 = 1 traps.
- Increment stays +4 in both cases.

Test Plan:
- Reset release, no stimulus for 3 cycles -> pc_o sequence 0x0, 0x4, 0x8, 0xC; flush_o=0.
- Stall: at pc_o=0x8, stall_i=1 for 2 cycles -> pc_o stays 0x8 for 2 cycles, then 0xC.
- Branch: br_taken_i=1, br_pc_i=0x40, br_offset_i=0xFFFF_FFF0 -> next pc_o=0x30; flush_o high exactly 2 cycles; a second br_taken_i during FLUSH is ignored.
- JALR and branch together: jalr_target_i=0x101, br_taken_i=1 -> pc_o=0x100; stall_i=1 in the same cycle is overridden.
- Misaligned: br_pc_i=0x10, br_offset_i=0x2 -> pc_o=0x100, misalign_o=1 until trap_ack_i, then pc_o=0x104. With RVC_TARGETS_EN defined -> pc_o=0x12, misalign_o=0.
- Wrap and reset: br_pc_i=0xFFFF_FFFC, br_offset_i=0x8 -> pc_o=0x4. rst mid-FLUSH -> pc_o=0x0 and flush_o=0 next cycle.
